// File: rtl/spi_adc_responder_pkg.sv
// Shared types and constants for the SPI ADC responder.
// Pin idle levels and the frame state encoding live here.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TRAIL = 2'd2
    } state_t;

    localparam logic CS_ACTIVE         = 1'b0;
    localparam logic CLK_IDLE          = 1'b0;
    localparam int   DEFAULT_ADC_WIDTH = 16;

endpackage

// File: rtl/spi_adc_responder_sync_edge_detect.sv
// Optional flip-flop synchronizer followed by one edge-detect register.
// Rise/fall strobes are registered, so a pin edge shows up STAGES+1 cycles later.
module sync_edge_detect #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic sig_in,
    output logic rise_out,
    output logic fall_out
);

    logic sync_out;
    logic prev_q;
    logic prev_d;
    logic rise_q;
    logic rise_d;
    logic fall_q;
    logic fall_d;

    generate
        if (STAGES == 0) begin : g_direct
            assign sync_out = sig_in;
        end else begin : g_sync
            logic [STAGES-1:0] sync_q;
            logic [STAGES-1:0] sync_d;

            always_comb begin
                sync_d[0] = sig_in;
                for (int i = 1; i < STAGES; i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in) begin
                    sync_q <= {STAGES{RST_VAL}};
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign sync_out = sync_q[STAGES-1];
        end
    endgenerate

    always_comb begin
        prev_d = sync_out;
        rise_d = sync_out & ~prev_q;
        fall_d = ~sync_out & prev_q;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_out = rise_q;
    assign fall_out = fall_q;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI peripheral emulating a serial ADC: shifts a held sample out MSB first,
// changing data on the falling edge of the controller's data clock.
module spi_adc_responder
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_ADC_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid_in,
    input  logic                  chip_sel_in,
    input  logic                  chip_clk_in,
    output logic                  chip_data_out,
    output logic                  busy_out,
    output logic                  frame_done_out,
    output logic                  frame_abort_out,
    output logic                  overrun_out,
    output logic                  underrun_out
);

    localparam int               CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic cs_rise;
    logic cs_fall;
    logic clk_fall;
    logic clk_rise_unused;

    state_t                  state_q,     state_d;
    logic [DATA_WIDTH-1:0]   shift_q,     shift_d;
    logic [CNT_W-1:0]        bit_cnt_q,   bit_cnt_d;
    logic                    data_q,      data_d;
    logic [DATA_WIDTH-1:0]   hold_q,      hold_d;
    logic                    hold_full_q, hold_full_d;
    logic                    done_q,      done_d;
    logic                    abort_q,     abort_d;
    logic                    overrun_q,   overrun_d;
    logic                    underrun_q,  underrun_d;

    logic                    frame_start;
    logic [DATA_WIDTH-1:0]   load_val;
    logic [DATA_WIDTH-1:0]   shifted;

    sync_edge_detect #(
        .STAGES (SYNC_STAGES),
        .RST_VAL(~CS_ACTIVE)
    ) u_cs_sync (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .sig_in  (chip_sel_in),
        .rise_out(cs_rise),
        .fall_out(cs_fall)
    );

    sync_edge_detect #(
        .STAGES (SYNC_STAGES),
        .RST_VAL(CLK_IDLE)
    ) u_clk_sync (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .sig_in  (chip_clk_in),
        .rise_out(clk_rise_unused),
        .fall_out(clk_fall)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        done_d      = 1'b0;
        abort_d     = 1'b0;
        overrun_d   = 1'b0;
        underrun_d  = 1'b0;
        load_val    = hold_q;
        shifted     = shift_q << 1;
        frame_start = (state_q == IDLE) && cs_fall;

        // A frame start consumes the holding register before any same-cycle write lands.
        if (frame_start) begin
            if (sample_valid_in) begin
                hold_d = sample_in;
                if (!hold_full_q) begin
                    load_val = sample_in;
                end
            end else if (hold_full_q) begin
                hold_full_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end else if (sample_valid_in) begin
            hold_d      = sample_in;
            hold_full_d = 1'b1;
            overrun_d   = hold_full_q;
        end

        case (state_q)
            IDLE: begin
                data_d = 1'b0;
                if (cs_fall) begin
                    shift_d   = load_val;
                    bit_cnt_d = '0;
                    data_d    = load_val[DATA_WIDTH-1];
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    data_d  = 1'b0;
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (clk_fall) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        data_d  = 1'b0;
                        state_d = TRAIL;
                    end else begin
                        shift_d   = shifted;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        data_d    = shifted[DATA_WIDTH-1];
                    end
                end
            end
            TRAIL: begin
                data_d = 1'b0;
                if (cs_rise) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                data_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            data_q      <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
        end
    end

    assign chip_data_out   = data_q;
    assign busy_out        = (state_q != IDLE);
    assign frame_done_out  = done_q;
    assign frame_abort_out = abort_q;
    assign overrun_out     = overrun_q;
    assign underrun_out    = underrun_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder acting as the SPI controller, with a
// queue of expected frames checked against the bits captured on chip_data_out.
module tb_spi_adc_responder;

    localparam int W       = 16;
    localparam int LOW_CYC = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] sample;
    logic         sample_vld;
    logic         cs;
    logic         sclk;
    logic         data_out;
    logic         busy;
    logic         done_p;
    logic         abort_p;
    logic         ovr_p;
    logic         udr_p;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    int n_abort = 0;
    int n_ovr = 0;
    int n_udr = 0;

    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    spi_adc_responder #(
        .DATA_WIDTH (W),
        .SYNC_STAGES(2)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .sample_in      (sample),
        .sample_valid_in(sample_vld),
        .chip_sel_in    (cs),
        .chip_clk_in    (sclk),
        .chip_data_out  (data_out),
        .busy_out       (busy),
        .frame_done_out (done_p),
        .frame_abort_out(abort_p),
        .overrun_out    (ovr_p),
        .underrun_out   (udr_p)
    );

    // Pulse counters; a pulse held for two cycles counts twice.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done_p)  n_done++;
            if (abort_p) n_abort++;
            if (ovr_p)   n_ovr++;
            if (udr_p)   n_udr++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_sample(input logic [W-1:0] v);
        sample     = v;
        sample_vld = 1'b1;
        tick();
        sample_vld = 1'b0;
        tick();
    endtask

    task automatic open_frame();
        cs = 1'b0;
        repeat (LOW_CYC) tick();
    endtask

    task automatic close_frame();
        cs = 1'b1;
        repeat (LOW_CYC) tick();
    endtask

    task automatic clock_bits(input int n, output logic [31:0] cap);
        cap = '0;
        for (int i = 0; i < n; i++) begin
            cap  = {cap[30:0], data_out};
            sclk = 1'b1;
            repeat (LOW_CYC) tick();
            sclk = 1'b0;
            repeat (LOW_CYC) tick();
        end
    endtask

    initial begin
        logic [31:0] cap;
        logic [W-1:0] e;
        int d0, a0, o0, u0;

        rst_n      = 1'b0;
        sample     = '0;
        sample_vld = 1'b0;
        cs         = 1'b1;
        sclk       = 1'b0;
        repeat (3) tick();

        check("rst_data",     32'(data_out), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done_p),   32'd0);
        check("rst_abort",    32'(abort_p),  32'd0);
        check("rst_overrun",  32'(ovr_p),    32'd0);
        check("rst_underrun", 32'(udr_p),    32'd0);

        rst_n = 1'b1;
        repeat (4) tick();

        // Plain frame.
        d0 = n_done; u0 = n_udr;
        write_sample(16'hA5C3);
        exp_q.push_back(16'hA5C3);
        open_frame();
        check("busy_open", 32'(busy), 32'd1);
        clock_bits(W, cap);
        e = exp_q.pop_front();
        check("frame_a5c3", cap, 32'(e));
        close_frame();
        check("done_a5c3",     32'(n_done - d0), 32'd1);
        check("underrun_a5c3", 32'(n_udr - u0),  32'd0);
        check("busy_closed",   32'(busy),        32'd0);

        // Abort after five clock falls, then resend with underrun.
        d0 = n_done; a0 = n_abort; u0 = n_udr;
        write_sample(16'h8001);
        exp_q.push_back(16'h8001);
        open_frame();
        clock_bits(5, cap);
        e = exp_q.pop_front();
        check("partial_8001", cap, 32'(e >> (W - 5)));
        close_frame();
        check("abort_pulse",  32'(n_abort - a0), 32'd1);
        check("abort_nodone", 32'(n_done - d0),  32'd0);
        check("abort_data",   32'(data_out),     32'd0);
        exp_q.push_back(16'h8001);
        open_frame();
        clock_bits(W, cap);
        e = exp_q.pop_front();
        check("resend_8001", cap, 32'(e));
        close_frame();
        check("resend_underrun", 32'(n_udr - u0), 32'd1);

        // Overrun: second write replaces the first.
        o0 = n_ovr; u0 = n_udr;
        write_sample(16'h1111);
        write_sample(16'h2222);
        check("overrun_pulse", 32'(n_ovr - o0), 32'd1);
        exp_q.push_back(16'h2222);
        open_frame();
        clock_bits(W, cap);
        e = exp_q.pop_front();
        check("frame_2222", cap, 32'(e));
        close_frame();
        check("underrun_2222", 32'(n_udr - u0), 32'd0);

        // Bypass: strobe lands in the cycle the internal cs_fall is consumed
        // (pin edge + 2 sync stages + edge register).
        o0 = n_ovr; u0 = n_udr;
        exp_q.push_back(16'h3333);
        cs = 1'b0;
        repeat (3) tick();
        sample     = 16'h3333;
        sample_vld = 1'b1;
        tick();
        sample_vld = 1'b0;
        repeat (LOW_CYC) tick();
        clock_bits(W, cap);
        e = exp_q.pop_front();
        check("bypass_3333", cap, 32'(e));
        close_frame();
        check("bypass_overrun",  32'(n_ovr - o0), 32'd0);
        check("bypass_underrun", 32'(n_udr - u0), 32'd0);

        // Extra clocks: four trailing zeros after the sample.
        d0 = n_done; a0 = n_abort;
        write_sample(16'hF00F);
        exp_q.push_back(16'hF00F);
        open_frame();
        clock_bits(W + 4, cap);
        e = exp_q.pop_front();
        check("extra_clk_f00f", cap, {12'h0, e, 4'h0});
        close_frame();
        check("extra_done",  32'(n_done - d0),  32'd1);
        check("extra_abort", 32'(n_abort - a0), 32'd0);

        // Asynchronous reset in the middle of a frame.
        write_sample(16'hFFFF);
        open_frame();
        clock_bits(8, cap);
        check("pre_reset_data", 32'(data_out), 32'd1);
        check("pre_reset_busy", 32'(busy),     32'd1);
        #2;
        rst_n = 1'b0;
        cs    = 1'b1;
        sclk  = 1'b0;
        #1;
        check("async_rst_data",     32'(data_out), 32'd0);
        check("async_rst_busy",     32'(busy),     32'd0);
        check("async_rst_done",     32'(done_p),   32'd0);
        check("async_rst_underrun", 32'(udr_p),    32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        u0 = n_udr;
        exp_q.push_back(16'h0000);
        open_frame();
        clock_bits(W, cap);
        e = exp_q.pop_front();
        check("post_reset_frame", cap, 32'(e));
        close_frame();
        check("post_reset_underrun", 32'(n_udr - u0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
